mem_scheduler: RTL and testbench
================================

MEM_SCHEDULER -- requirements
Module: mem_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 36, trace address width.
REQ-002 SHALL have parameter BG_BITS, default 2, bank-group field width.
REQ-003 SHALL have parameter BA_BITS, default 2, bank field width.
REQ-004 SHALL have parameter ROW_BITS, default 15, row field width.
REQ-005 SHALL have parameter COL_BITS, default 11, column field width; the remaining low bits of the address are the byte offset, ignored.
REQ-006 SHALL have parameter QUEUE_DEPTH, default 16, request queue entries, a power of two and at least 2.
REQ-007 SHALL have parameters T_RCD, T_RP and T_BURST, each default 4 and at least 1, in clock cycles.
REQ-008 SHALL have port: clock  in  1  single clock, all logic on posedge.
REQ-009 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-010 SHALL have port: req_valid  in  1  request offered.
REQ-011 SHALL have port: req_ready  out  1  queue can accept.
REQ-012 SHALL have port: req_op  in  2  0 read, 1 write, 2 ifetch (read); 3 is illegal.
REQ-013 SHALL have port: req_addr  in  ADDR_WIDTH  fields from MSB: bank group, bank, row, column, offset.
REQ-014 SHALL have port: cmd_valid  out  1  one-cycle command strobe.
REQ-015 SHALL have port: cmd  out  3  0 NOP, 1 ACT, 2 PRE, 3 RD, 4 WR.
REQ-016 SHALL have ports: cmd_bg, cmd_ba, cmd_row, cmd_col  out  BG_BITS/BA_BITS/ROW_BITS/COL_BITS  command target.
REQ-017 SHALL have port: hit_count  out  32  saturating row-hit counter.
REQ-018 SHALL have port: miss_count  out  32  saturating row-miss counter; empty-bank accesses count in neither counter.
REQ-019 SHALL have port: idle  out  1  high when the queue is empty and the FSM is in IDLE.

Function
REQ-020 SHALL accept a request on a cycle where req_valid and req_ready are both high, and push it to a FIFO of QUEUE_DEPTH entries.
REQ-021 SHALL drive req_ready = !full; when the queue is full, it SHALL stay low even if a pop occurs in the same cycle.
REQ-022 SHALL drop req_op==3 requests without enqueueing them, while req_ready behaves normally.
REQ-023 SHALL keep, per bank (2^(BG_BITS+BA_BITS) entries), an open flag and an open row.
REQ-024 SHALL implement FSM states IDLE, DECODE, PRECHARGE, ACTIVATE, ACCESS and WAIT, processing requests strictly in order with one request outstanding.
REQ-025 In IDLE, when the queue is not empty, SHALL pop the head and go to DECODE.
REQ-026 In DECODE, SHALL go to ACCESS and increment hit_count when the bank is open and the row matches (hit).
REQ-027 In DECODE, SHALL go to ACTIVATE when the bank is closed (empty).
REQ-028 In DECODE, SHALL go to PRECHARGE and increment miss_count when the bank is open with a different row (miss).
REQ-029 On the first cycle of PRECHARGE, ACTIVATE or ACCESS, SHALL pulse cmd_valid with the matching command and load a down-counter.
REQ-030 SHALL issue PRE exactly T_RP cycles before the following ACT, then clear the bank's open flag.
REQ-031 SHALL issue ACT exactly T_RCD cycles before the following RD/WR, then set the bank's open flag and record the row.
REQ-032 SHALL issue RD for op 0/2 and WR for op 1, then hold in WAIT for T_BURST cycles before returning to IDLE.
REQ-033 SHALL give a hit a fixed latency: pop in cycle N, DECODE in N+1, RD/WR in N+2.
REQ-034 SHALL drive cmd=NOP, with cmd_valid low and target fields held, whenever no command is issued.
REQ-035 SHALL wrap the queue pointers modulo QUEUE_DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-036 SHALL saturate each counter at 32'hFFFF_FFFF.

Reset
REQ-037 SHALL, on reset, flush the queue, close every bank, zero both counters, and place the FSM in IDLE.
REQ-038 SHALL drive these values in the cycle after reset: req_ready=1, cmd_valid=0, cmd=NOP, cmd_* targets=0, idle=1.
REQ-039 SHALL abort any in-flight request on reset asserted mid-operation, issuing no further command.
REQ-040 SHALL ignore a request offered while reset is high.

Configuration
REQ-041 With CLOSED_PAGE_EN defined, SHALL issue PRE to the same bank immediately after the T_BURST wait in ACCESS, wait T_RP more cycles, and leave the bank closed, so hit_count and miss_count stay 0.
REQ-042 Without CLOSED_PAGE_EN, SHALL use an open-page policy: rows stay open until a miss.

Verification
REQ-043 SHALL cover: reset, then a read to bg0/ba0/row 5/col 8 -> ACT(row 5), RD(col 8) 4 cycles later; hit_count=0, miss_count=0.
REQ-044 SHALL cover: a second read to the same bank and row 5 -> RD only, 2 cycles after pop; hit_count=1.
REQ-045 SHALL cover: a read to the same bank at row 9 -> PRE, ACT 4 cycles later, RD 4 cycles after that; miss_count=1.
REQ-046 SHALL cover: 17 back-to-back offers while the FSM is stalled -> exactly 16 accepted, req_ready low on the 17th, and commands in FIFO order.
REQ-047 SHALL cover: reset asserted the cycle after an ACT -> no RD issued, idle=1 next cycle, and the next request to that bank issues ACT.
REQ-048 SHALL cover: CLOSED_PAGE_EN with two reads to row 5 -> each is ACT, RD, PRE; hit_count=0.

Source files
------------

// File: rtl/mem_scheduler.sv
// mem_scheduler: in-order DRAM command scheduler with a request FIFO and per-bank open-row tracking.
// Define CLOSED_PAGE_EN to precharge after every access; the default build keeps rows open until a miss.
module mem_scheduler #(
    parameter int ADDR_WIDTH  = 36,
    parameter int BG_BITS     = 2,
    parameter int BA_BITS     = 2,
    parameter int ROW_BITS    = 15,
    parameter int COL_BITS    = 11,
    parameter int QUEUE_DEPTH = 16,
    parameter int T_RCD       = 4,
    parameter int T_RP        = 4,
    parameter int T_BURST     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  cmd_valid,
    output logic [2:0]            cmd,
    output logic [BG_BITS-1:0]    cmd_bg,
    output logic [BA_BITS-1:0]    cmd_ba,
    output logic [ROW_BITS-1:0]   cmd_row,
    output logic [COL_BITS-1:0]   cmd_col,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic                  idle
);
    localparam int BK_BITS = BG_BITS + BA_BITS;
    localparam int NB = 1 << BK_BITS;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int OFF = ADDR_WIDTH - BK_BITS - ROW_BITS - COL_BITS;
    localparam int EW = 1 + BK_BITS + ROW_BITS + COL_BITS;
    localparam int CW = 16;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, PRE = 3'd2, RD = 3'd3, WR = 3'd4;

    typedef enum logic [2:0] {IDLE, DECODE, PRECHARGE, ACTIVATE, ACCESS, WAIT} state_t;

    logic [EW-1:0] mem_q [QUEUE_DEPTH];
    logic [PW:0] wp_q, wp_d, rp_q, rp_d;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] cur_q, cur_d;
    logic [NB-1:0] open_q, open_d;
    logic [ROW_BITS-1:0] row_q [NB];
    logic [ROW_BITS-1:0] row_d [NB];
    logic [31:0] hit_q, hit_d, miss_q, miss_d;
    logic cmd_valid_q, cmd_valid_d, cl_q, cl_d;
    logic [2:0] cmd_q, cmd_d, rw;
    logic [BG_BITS-1:0] tbg_q, tbg_d;
    logic [BA_BITS-1:0] tba_q, tba_d;
    logic [ROW_BITS-1:0] trow_q, trow_d, row;
    logic [COL_BITS-1:0] tcol_q, tcol_d, col;
    logic [BK_BITS-1:0] bk;
    logic empty, full, push, pop, unused_off;

    assign unused_off = ^req_addr[OFF-1:0];
    assign empty = wp_q == rp_q;
    assign full = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
    assign req_ready = !full;
    assign push = req_valid && !full && req_op != 2'd3;
    assign pop = state_q == IDLE && !empty;
    assign bk = cur_q[EW-2 -: BK_BITS];
    assign row = cur_q[COL_BITS +: ROW_BITS];
    assign col = cur_q[COL_BITS-1:0];
    assign rw = cur_q[EW-1] ? WR : RD;

    always_ff @(posedge clock)
        if (push) mem_q[wp_q[PW-1:0]] <= {req_op == 2'd1, req_addr[ADDR_WIDTH-1 -: BK_BITS+ROW_BITS], req_addr[OFF +: COL_BITS]};

    always_comb begin
        wp_d = wp_q + (PW+1)'(push);
        rp_d = rp_q + (PW+1)'(pop);
        cur_d = pop ? mem_q[rp_q[PW-1:0]] : cur_q;
        state_d = state_q;
        cnt_d = cnt_q;
        open_d = open_q;
        row_d = row_q;
        hit_d = hit_q;
        miss_d = miss_q;
        cl_d = cl_q;
        cmd_valid_d = 1'b0;
        cmd_d = NOP;
        case (state_q)
            IDLE: if (!empty) state_d = DECODE;
            DECODE: begin
                cmd_valid_d = 1'b1;
                if (open_q[bk] && row_q[bk] == row) begin
                    state_d = ACCESS;
                    cmd_d = rw;
                    hit_d = hit_q + 32'(hit_q != '1);
                end else if (!open_q[bk]) begin
                    state_d = ACTIVATE;
                    cmd_d = ACT;
                    cnt_d = CW'(T_RCD - 1);
                    open_d[bk] = 1'b1;
                    row_d[bk] = row;
                end else begin
                    state_d = PRECHARGE;
                    cmd_d = PRE;
                    cnt_d = CW'(T_RP - 1);
                    open_d[bk] = 1'b0;
                    miss_d = miss_q + 32'(miss_q != '1);
                end
            end
            PRECHARGE:
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else if (cl_q) begin
                    state_d = IDLE;
                    cl_d = 1'b0;
                end else begin
                    state_d = ACTIVATE;
                    cmd_valid_d = 1'b1;
                    cmd_d = ACT;
                    cnt_d = CW'(T_RCD - 1);
                    open_d[bk] = 1'b1;
                    row_d[bk] = row;
                end
            ACTIVATE:
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else begin
                    state_d = ACCESS;
                    cmd_valid_d = 1'b1;
                    cmd_d = rw;
                end
            ACCESS: begin
                state_d = WAIT;
                cnt_d = CW'(T_BURST - 1);
            end
            WAIT:
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else begin
`ifdef CLOSED_PAGE_EN
                    state_d = PRECHARGE;
                    cmd_valid_d = 1'b1;
                    cmd_d = PRE;
                    cnt_d = CW'(T_RP - 1);
                    open_d[bk] = 1'b0;
                    cl_d = 1'b1;
`else
                    state_d = IDLE;
`endif
                end
            default: state_d = IDLE;
        endcase
        // targets follow the current request on every command and hold otherwise
        tbg_d = cmd_valid_d ? bk[BK_BITS-1 -: BG_BITS] : tbg_q;
        tba_d = cmd_valid_d ? bk[BA_BITS-1:0] : tba_q;
        trow_d = cmd_valid_d ? row : trow_q;
        tcol_d = cmd_valid_d ? col : tcol_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
            state_q <= IDLE;
            cnt_q <= '0;
            cur_q <= '0;
            open_q <= '0;
            row_q <= '{default: '0};
            hit_q <= '0;
            miss_q <= '0;
            cl_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q <= NOP;
            tbg_q <= '0;
            tba_q <= '0;
            trow_q <= '0;
            tcol_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            cur_q <= cur_d;
            open_q <= open_d;
            row_q <= row_d;
            hit_q <= hit_d;
            miss_q <= miss_d;
            cl_q <= cl_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q <= cmd_d;
            tbg_q <= tbg_d;
            tba_q <= tba_d;
            trow_q <= trow_d;
            tcol_q <= tcol_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd = cmd_q;
    assign cmd_bg = tbg_q;
    assign cmd_ba = tba_q;
    assign cmd_row = trow_q;
    assign cmd_col = tcol_q;
    assign hit_count = hit_q;
    assign miss_count = miss_q;
    assign idle = empty && state_q == IDLE;
endmodule

// File: tb/tb_mem_scheduler.sv
// tb_mem_scheduler: directed bench for mem_scheduler; open-page sequence by default, closed-page
// sequence when CLOSED_PAGE_EN is defined.
`timescale 1ns/1ps
module tb_mem_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic [35:0] req_addr = '0;
    logic req_ready, cmd_valid, idle;
    logic [2:0] cmd;
    logic [1:0] cmd_bg, cmd_ba;
    logic [14:0] cmd_row;
    logic [10:0] cmd_col;
    logic [31:0] hit_count, miss_count;
    int total = 0, bad = 0, cyc = 0, c0 = 0, ca = 0;
    logic rdy;

    typedef struct {int cyc; logic [2:0] c; logic [1:0] bg; logic [1:0] ba; logic [14:0] row; logic [10:0] col;} ent_t;
    ent_t log_q[$];

    mem_scheduler dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .hit_count(hit_count), .miss_count(miss_count), .idle(idle)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (cmd_valid) log_q.push_back('{cyc, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [1:0] op, input logic [1:0] ba, input int row, input int col);
        @(negedge clock);
        req_valid = 1'b1;
        req_op = op;
        req_addr = {2'd0, ba, row[14:0], col[10:0], 6'd0};
        c0 = cyc;
        #1 rdy = req_ready;
    endtask

    task automatic drop_req;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!idle && n < max);
        chk("idle_reached", idle, 1'b1);
    endtask

    task automatic chk_cmd(input string tag, input logic [2:0] c, input logic [1:0] ba, input int row, input int col, input int at);
        ent_t e;
        #1;
        chk($sformatf("%s_present", tag), log_q.size() > 0, 1'b1);
        if (log_q.size() > 0) begin
            e = log_q.pop_front();
            chk($sformatf("%s_cmd", tag), e.c, c);
            chk($sformatf("%s_bg", tag), e.bg, 2'd0);
            chk($sformatf("%s_ba", tag), e.ba, ba);
            if (row >= 0) chk($sformatf("%s_row", tag), e.row, row[14:0]);
            if (col >= 0) chk($sformatf("%s_col", tag), e.col, col[10:0]);
            chk($sformatf("%s_cyc", tag), e.cyc, at);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_cmd", cmd, 3'd0);
        chk("rst_targets", {cmd_bg, cmd_ba, cmd_row, cmd_col}, 30'd0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
`ifndef CLOSED_PAGE_EN
        // empty bank: ACT then RD four cycles later
        offer(2'd0, 2'd0, 5, 8);
        chk("t1_rdy", rdy, 1'b1);
        drop_req;
        wait_idle(40);
        chk_cmd("t1_act", 3'd1, 2'd0, 5, -1, c0 + 3);
        chk_cmd("t1_rd", 3'd3, 2'd0, -1, 8, c0 + 7);
        chk("t1_hits", hit_count, 32'd0);
        chk("t1_misses", miss_count, 32'd0);
        // row hit: RD two cycles after pop
        offer(2'd2, 2'd0, 5, 12);
        drop_req;
        wait_idle(40);
        chk_cmd("t2_rd", 3'd3, 2'd0, -1, 12, c0 + 3);
        chk("t2_hits", hit_count, 32'd1);
        // row miss: PRE, ACT, RD
        offer(2'd0, 2'd0, 9, 1);
        drop_req;
        wait_idle(40);
        chk_cmd("t3_pre", 3'd2, 2'd0, -1, -1, c0 + 3);
        chk_cmd("t3_act", 3'd1, 2'd0, 9, -1, c0 + 7);
        chk_cmd("t3_rd", 3'd3, 2'd0, -1, 1, c0 + 11);
        chk("t3_misses", miss_count, 32'd1);
        chk("t3_hits", hit_count, 32'd1);
        // two misses stall the FSM while 17 more requests are offered back to back
        offer(2'd0, 2'd0, 3, 0);
        ca = c0;
        offer(2'd0, 2'd0, 9, 0);
        for (int i = 1; i <= 17; i++) begin
            offer(2'(i % 2), 2'd0, 9, i);
            chk($sformatf("t4_rdy%0d", i), rdy, i <= 16);
        end
        drop_req;
        wait_idle(400);
        chk_cmd("t4a_pre", 3'd2, 2'd0, -1, -1, ca + 3);
        chk_cmd("t4a_act", 3'd1, 2'd0, 3, -1, ca + 7);
        chk_cmd("t4a_rd", 3'd3, 2'd0, -1, 0, ca + 11);
        chk_cmd("t4b_pre", 3'd2, 2'd0, -1, -1, ca + 18);
        chk_cmd("t4b_act", 3'd1, 2'd0, 9, -1, ca + 22);
        chk_cmd("t4b_rd", 3'd3, 2'd0, -1, 0, ca + 26);
        for (int i = 1; i <= 16; i++)
            chk_cmd($sformatf("t4_q%0d", i), (i % 2) ? 3'd4 : 3'd3, 2'd0, -1, i, ca + 33 + 7 * (i - 1));
        chk("t4_log_drained", log_q.size(), 0);
        chk("t4_hits", hit_count, 32'd17);
        chk("t4_misses", miss_count, 32'd3);
        // illegal op is dropped
        offer(2'd3, 2'd0, 9, 20);
        chk("t5_rdy", rdy, 1'b1);
        drop_req;
        repeat (6) @(negedge clock);
        chk("t5_idle", idle, 1'b1);
        #1 chk("t5_nolog", log_q.size(), 0);
        // reset the cycle after an ACT, with a request offered during reset
        offer(2'd0, 2'd1, 7, 2);
        drop_req;
        begin
            int n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!cmd_valid && n < 20);
        end
        chk("t6_act_seen", cmd_valid, 1'b1);
        chk_cmd("t6_act", 3'd1, 2'd1, 7, -1, c0 + 3);
        @(negedge clock);
        reset = 1'b1;
        req_valid = 1'b1;
        req_op = 2'd0;
        req_addr = {2'd0, 2'd2, 15'd4, 11'd4, 6'd0};
        @(negedge clock);
        reset = 1'b0;
        req_valid = 1'b0;
        chk("t6_idle", idle, 1'b1);
        chk("t6_cmd_valid", cmd_valid, 1'b0);
        chk("t6_hits", hit_count, 32'd0);
        chk("t6_misses", miss_count, 32'd0);
        repeat (10) @(negedge clock);
        #1 chk("t6_no_rd", log_q.size(), 0);
        offer(2'd1, 2'd1, 7, 2);
        drop_req;
        wait_idle(40);
        chk_cmd("t7_act", 3'd1, 2'd1, 7, -1, c0 + 3);
        chk_cmd("t7_wr", 3'd4, 2'd1, -1, 2, c0 + 7);
        chk("t7_hits", hit_count, 32'd0);
`else
        for (int k = 0; k < 2; k++) begin
            offer(2'd0, 2'd0, 5, 8);
            chk($sformatf("cp%0d_rdy", k), rdy, 1'b1);
            drop_req;
            wait_idle(40);
            chk_cmd($sformatf("cp%0d_act", k), 3'd1, 2'd0, 5, -1, c0 + 3);
            chk_cmd($sformatf("cp%0d_rd", k), 3'd3, 2'd0, -1, 8, c0 + 7);
            chk_cmd($sformatf("cp%0d_pre", k), 3'd2, 2'd0, -1, -1, c0 + 12);
            chk($sformatf("cp%0d_idle_cyc", k), cyc, c0 + 16);
        end
        chk("cp_hits", hit_count, 32'd0);
        chk("cp_misses", miss_count, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
